rotor_step_ctrl: RTL and testbench
==================================

ROTOR_STEP_CTRL -- requirements
Module: rotor_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key edge (20 ms at 50 MHz).
REQ-002 Parameter NOTCH_R, 16, right-rotor turnover position (Q).
REQ-003 Parameter NOTCH_M, 4, middle-rotor turnover position (E).
REQ-004 Port CLOCK_50  input  1  the single clock.
REQ-005 Port RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 Port key_n  input  1  raw active-low letter key, asynchronous to CLOCK_50.
REQ-007 Port load_init  input  1  level; loads initial positions.
REQ-008 Port init_r, init_m, init_l  input  5 each  initial positions.
REQ-009 Port pos_r, pos_m, pos_l  output  5 each  current rotor positions, 0..25.
REQ-010 Port step_pulse  output  1  one-cycle strobe on every rotor advance.
REQ-011 Port key_held  output  1  debounced key state, 1 = pressed.

Function
REQ-012 key_n SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 FSM SHALL have states IDLE, PRESS_WAIT, STEP, HELD, RELEASE_WAIT.
REQ-014 IDLE: synchronized key low -> PRESS_WAIT, counter cleared.
REQ-015 PRESS_WAIT: key low for DEBOUNCE_CYCLES consecutive cycles -> STEP; any high sample -> IDLE.
REQ-016 STEP SHALL last exactly one cycle, assert step_pulse, update positions at its end, then -> HELD.
REQ-017 HELD: key high -> RELEASE_WAIT; holding the key SHALL never produce further steps.
REQ-018 RELEASE_WAIT: key high for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any low sample -> HELD.
REQ-019 key_held SHALL be 1 in STEP, HELD and RELEASE_WAIT, else 0.
REQ-020 Right rotor SHALL advance on every step.
REQ-021 Middle rotor SHALL advance when pre-step pos_r == NOTCH_R (plus REQ-030).
REQ-022 Left rotor SHALL advance when pre-step pos_m == NOTCH_M.
REQ-023 Advance SHALL wrap 25 -> 0; positions SHALL never hold 26..31.
REQ-024 load_init high SHALL load all positions next edge; init values 26..31 SHALL load as value-26.
REQ-025 load_init SHALL take priority over a coincident STEP; the step is discarded, step_pulse still asserts, FSM proceeds to HELD.

Reset
REQ-026 RESET_N low SHALL immediately force FSM to IDLE, counter and synchronizer to 0 (idle key = high for sync flops, i.e. sync flops reset to 1).
REQ-027 Reset values: pos_r = pos_m = pos_l = 0, step_pulse = 0, key_held = 0.
REQ-028 Reset mid-debounce or mid-HELD SHALL discard the press; a key still held after reset release SHALL be debounced anew and step once.

Configuration
REQ-029 Macro ROTOR_DOUBLE_STEP_EN SHALL select the historical double-step anomaly.
REQ-030 With ROTOR_DOUBLE_STEP_EN: middle rotor also advances when pre-step pos_m == NOTCH_M (middle and left step together).
REQ-031 Without it: middle advances only per REQ-021 (pure odometer).

Structure
REQ-032 Package enigma_pkg SHALL hold LETTER_W = 5, ALPHABET = 26, default notch constants, and the FSM state enum.
REQ-033 Sub-module key_debouncer SHALL contain synchronizer, counter and FSM, outputting step strobe and key_held; position arithmetic stays in rotor_step_ctrl.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 Reset, key_n low 4 cycles then high 10 -> exactly one step_pulse, pos_r 0 -> 1, others 0.
REQ-035 key_n glitches low 2 cycles, high 6 -> no step_pulse, key_held stays 0; held low 100 cycles -> exactly one step.
REQ-036 Load (r,m,l) = (16,0,0), one press -> (17,1,0); load (25,25,25), press -> (0,25,25).
REQ-037 Load (16,4,7), press: with ROTOR_DOUBLE_STEP_EN -> (17,5,8); without -> (17,5,8); then load (5,4,7), press: with -> (6,5,8), without -> (6,4,8).
REQ-038 load_init = 1 during STEP cycle with init (3,3,3) -> positions (3,3,3), step_pulse = 1 once; load (30,26,31) -> (4,0,5).
REQ-039 RESET_N low in PRESS_WAIT and HELD -> positions 0, key_held 0 asynchronously; key still low after release -> one step after 4+2 cycles.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, FSM state encoding and letter arithmetic for the rotor stepping logic.
package enigma_pkg;

    localparam int LETTER_W    = 5;
    localparam int ALPHABET    = 26;
    localparam int NOTCH_R_DEF = 16;
    localparam int NOTCH_M_DEF = 4;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        STEP         = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_t;

    function automatic logic [LETTER_W-1:0] letter_inc(input logic [LETTER_W-1:0] v);
        return (v >= LETTER_W'(ALPHABET - 1)) ? '0 : v + LETTER_W'(1);
    endfunction

    // Folds out-of-alphabet codes 26..31 back onto 0..5.
    function automatic logic [LETTER_W-1:0] letter_norm(input logic [LETTER_W-1:0] v);
        return (v >= LETTER_W'(ALPHABET)) ? v - LETTER_W'(ALPHABET) : v;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces the raw letter key; emits one step strobe per accepted press.
// Handshake: step is a single-cycle strobe (no ready); key_held is a level, 1 from STEP until release is accepted.
module key_debouncer
    import enigma_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       step,
    output logic       key_held,
    output logic [2:0] state
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit                SINGLE   = (DEBOUNCE_CYCLES <= 1);

    logic [1:0]       sync;
    logic             key_low;
    logic [CNT_W-1:0] cnt;
    key_state_t       fsm;

    // Idle key level is high, so the synchronizer resets to 1s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign key_low = ~sync[1];
    assign state   = fsm;

    // The sample that leaves IDLE/HELD is the first of the stable window, hence cnt starts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            cnt      <= '0;
            step     <= 1'b0;
            key_held <= 1'b0;
        end else begin
            step <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (key_low) begin
                        cnt <= CNT_W'(1);
                        if (SINGLE) begin
                            fsm      <= STEP;
                            step     <= 1'b1;
                            key_held <= 1'b1;
                        end else begin
                            fsm <= PRESS_WAIT;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_low) begin
                        fsm <= IDLE;
                        cnt <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        fsm      <= STEP;
                        step     <= 1'b1;
                        key_held <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STEP: begin
                    fsm <= HELD;
                end
                HELD: begin
                    if (!key_low) begin
                        cnt <= CNT_W'(1);
                        if (SINGLE) begin
                            fsm      <= IDLE;
                            key_held <= 1'b0;
                        end else begin
                            fsm <= RELEASE_WAIT;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (key_low) begin
                        fsm <= HELD;
                        cnt <= '0;
                    end else if (cnt >= CNT_LAST) begin
                        fsm      <= IDLE;
                        key_held <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    fsm      <= IDLE;
                    cnt      <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rotor_step_ctrl.sv
// Three-rotor stepping controller: one debounced key press advances the rotors once.
// Define ROTOR_DOUBLE_STEP_EN to reproduce the historical middle-rotor double step.
module rotor_step_ctrl
    import enigma_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NOTCH_R         = NOTCH_R_DEF,
    parameter int NOTCH_M         = NOTCH_M_DEF
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       key_n,
    input  logic       load_init,
    input  logic [4:0] init_r,
    input  logic [4:0] init_m,
    input  logic [4:0] init_l,
    output logic [4:0] pos_r,
    output logic [4:0] pos_m,
    output logic [4:0] pos_l,
    output logic       step_pulse,
    output logic       key_held,
    output logic [2:0] fsm_state
);

`ifdef ROTOR_DOUBLE_STEP_EN
    localparam bit DOUBLE_STEP = 1'b1;
`else
    localparam bit DOUBLE_STEP = 1'b0;
`endif

    localparam logic [LETTER_W-1:0] NOTCH_R_POS = LETTER_W'(NOTCH_R);
    localparam logic [LETTER_W-1:0] NOTCH_M_POS = LETTER_W'(NOTCH_M);

    logic adv_m;
    logic adv_l;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .key_n    (key_n),
        .step     (step_pulse),
        .key_held (key_held),
        .state    (fsm_state)
    );

    // Turnover decisions use the pre-step positions.
    always_comb begin
        adv_m = (pos_r == NOTCH_R_POS) | (DOUBLE_STEP & (pos_m == NOTCH_M_POS));
        adv_l = (pos_m == NOTCH_M_POS);
    end

    // A load coinciding with STEP wins; that step is dropped.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pos_r <= '0;
            pos_m <= '0;
            pos_l <= '0;
        end else if (load_init) begin
            pos_r <= letter_norm(init_r);
            pos_m <= letter_norm(init_m);
            pos_l <= letter_norm(init_l);
        end else if (step_pulse) begin
            pos_r <= letter_inc(pos_r);
            if (adv_m) pos_m <= letter_inc(pos_m);
            if (adv_l) pos_l <= letter_inc(pos_l);
        end
    end

endmodule

// File: tb/tb_rotor_step_ctrl.sv
// Directed bench for rotor_step_ctrl with DEBOUNCE_CYCLES = 4 and a position scoreboard.
module tb_rotor_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       load_init = 1'b0;
    logic [4:0] init_r = '0;
    logic [4:0] init_m = '0;
    logic [4:0] init_l = '0;
    logic [4:0] pos_r, pos_m, pos_l;
    logic       step_pulse, key_held;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int p0;
    int cyc;
    logic seen;
    logic pend = 1'b0;
    logic [14:0] exp_q[$];
    logic [14:0] exp_pos;
    logic [4:0] mr = 0, mm = 0, ml = 0;

    rotor_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .NOTCH_R(16),
        .NOTCH_M(4)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .key_n     (key_n),
        .load_init (load_init),
        .init_r    (init_r),
        .init_m    (init_m),
        .init_l    (init_l),
        .pos_r     (pos_r),
        .pos_m     (pos_m),
        .pos_l     (pos_l),
        .step_pulse(step_pulse),
        .key_held  (key_held),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : v + 5'd1;
    endfunction

    // Reference model of one rotor advance, applied to mr/mm/ml.
    task automatic model_step();
        logic mid, lft;
        mid = (mr == 5'd16);
`ifdef ROTOR_DOUBLE_STEP_EN
        mid = mid | (mm == 5'd4);
`endif
        lft = (mm == 5'd4);
        mr = inc26(mr);
        if (mid) mm = inc26(mm);
        if (lft) ml = inc26(ml);
    endtask

    task automatic expect_step();
        model_step();
        exp_q.push_back({mr, mm, ml});
    endtask

    task automatic press(input int lo, input int hi);
        @(posedge clk);
        key_n = 1'b0;
        repeat (lo) @(posedge clk);
        key_n = 1'b1;
        repeat (hi) @(posedge clk);
    endtask

    task automatic load(input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
        @(negedge clk);
        load_init = 1'b1;
        init_r = r;
        init_m = m;
        init_l = l;
        @(negedge clk);
        load_init = 1'b0;
        mr = (r >= 26) ? r - 5'd26 : r;
        mm = (m >= 26) ? m - 5'd26 : m;
        ml = (l >= 26) ? l - 5'd26 : l;
    endtask

    task automatic wait_pulse(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!step_pulse && cycles < 50);
    endtask

    task automatic check_pos(input string tag, input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
        check({tag, "_r"}, pos_r, r);
        check({tag, "_m"}, pos_m, m);
        check({tag, "_l"}, pos_l, l);
    endtask

    // Scoreboard: each step_pulse must match a queued expectation, compared once positions update.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() != 0) begin
                exp_pos = exp_q.pop_front();
                check("sb_pos", {pos_r, pos_m, pos_l}, exp_pos);
            end
        end
        if (step_pulse && rst_n) begin
            n_pulses++;
            check("sb_step_expected", exp_q.size() != 0, 1);
            pend = 1'b1;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_pos("reset_pos", 0, 0, 0);
        check("reset_step_pulse", step_pulse, 0);
        check("reset_key_held", key_held, 0);
        check("reset_state", fsm_state, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic press: 4 low cycles then release.
        p0 = n_pulses;
        expect_step();
        press(4, 10);
        @(negedge clk);
        check("basic_pulses", n_pulses - p0, 1);
        check("basic_key_held", key_held, 0);
        check_pos("basic_pos", 1, 0, 0);

        // Short glitch must be rejected.
        p0 = n_pulses;
        seen = 1'b0;
        @(posedge clk);
        key_n = 1'b0;
        repeat (2) begin @(negedge clk); seen = seen | key_held; end
        key_n = 1'b1;
        repeat (6) begin @(negedge clk); seen = seen | key_held; end
        check("glitch_key_held", seen, 0);
        check("glitch_pulses", n_pulses - p0, 0);
        check("glitch_state", fsm_state, 0);

        // Long hold gives exactly one step.
        p0 = n_pulses;
        expect_step();
        @(posedge clk);
        key_n = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("hold_key_held", key_held, 1);
        check("hold_state", fsm_state, 3);
        key_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("hold_pulses", n_pulses - p0, 1);
        check("hold_release", key_held, 0);
        check_pos("hold_pos", 2, 0, 0);

        // Right-rotor turnover and wrap.
        load(16, 0, 0);
        check_pos("load1", 16, 0, 0);
        expect_step();
        press(4, 10);
        @(negedge clk);
        check_pos("turn_r", 17, 1, 0);
        load(25, 25, 25);
        expect_step();
        press(4, 10);
        @(negedge clk);
        check_pos("wrap_r", 0, 25, 25);

        // Middle-notch behaviour.
        load(16, 4, 7);
        expect_step();
        press(4, 10);
        @(negedge clk);
        check_pos("notch_both", 17, 5, 8);
        load(5, 4, 7);
        expect_step();
        press(4, 10);
        @(negedge clk);
`ifdef ROTOR_DOUBLE_STEP_EN
        check_pos("double_step", 6, 5, 8);
`else
        check_pos("odometer", 6, 4, 8);
`endif

        // Load during the STEP cycle wins over the step.
        p0 = n_pulses;
        mr = 3; mm = 3; ml = 3;
        exp_q.push_back({5'd3, 5'd3, 5'd3});
        @(posedge clk);
        key_n = 1'b0;
        wait_pulse(cyc);
        check("ldstep_found", cyc < 50, 1);
        load_init = 1'b1;
        init_r = 3; init_m = 3; init_l = 3;
        @(posedge clk);
        #1 load_init = 1'b0;
        @(negedge clk);
        check_pos("ldstep_pos", 3, 3, 3);
        check("ldstep_state", fsm_state, 3);
        key_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ldstep_pulses", n_pulses - p0, 1);
        load(30, 26, 31);
        check_pos("load_fold", 4, 0, 5);

        // Reset in PRESS_WAIT, key kept low through reset.
        @(posedge clk);
        key_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pw_state", fsm_state, 1);
        #2 rst_n = 1'b0;
        #1;
        check_pos("pw_rst_pos", 0, 0, 0);
        check("pw_rst_key_held", key_held, 0);
        mr = 0; mm = 0; ml = 0;
        repeat (2) @(negedge clk);
        p0 = n_pulses;
        expect_step();
        rst_n = 1'b1;
        wait_pulse(cyc);
        check("pw_restep_cycles", cyc, 6);
        key_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pw_pulses", n_pulses - p0, 1);
        check_pos("pw_pos", 1, 0, 0);

        // Reset while HELD.
        expect_step();
        @(posedge clk);
        key_n = 1'b0;
        wait_pulse(cyc);
        check("held_first_found", cyc < 50, 1);
        repeat (3) @(negedge clk);
        check("held_state", fsm_state, 3);
        check_pos("held_pos", 2, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_pos("held_rst_pos", 0, 0, 0);
        check("held_rst_key_held", key_held, 0);
        mr = 0; mm = 0; ml = 0;
        repeat (2) @(negedge clk);
        p0 = n_pulses;
        expect_step();
        rst_n = 1'b1;
        wait_pulse(cyc);
        check("held_restep_cycles", cyc, 6);
        repeat (20) @(negedge clk);
        check("held_no_repeat", n_pulses - p0, 1);
        key_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_pos("held_pos_end", 1, 0, 0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
